posit_decode_pipe: RTL and testbench
====================================

POSIT_DECODE_PIPE -- requirements
Module: posit_decode_pipe

Interface
REQ-001 Parameter N, default 8: posit width in bits, legal 4..32.
REQ-002 Parameter ES, default 0: exponent field width, legal 0..3 with ES <= N-3.
REQ-003 Derived constants: SW = $clog2((N-2)<<ES)+2 (scale width); FW = N-2-ES (fraction width, hidden bit included).
REQ-004 clk  input  1  rising-edge clock; the only clock.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  in_posit is valid.
REQ-007 in_ready  output  1  block accepts in_posit this cycle.
REQ-008 in_posit  input  N  posit word.
REQ-009 out_valid  output  1  decoded result valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_sign  output  1  sign bit of the posit.
REQ-012 out_scale  output  SW  signed scale, k*2^ES + e.
REQ-013 out_frac  output  FW  unsigned <1.FW-1> magnitude with hidden 1 at MSB.
REQ-014 out_zero  output  1  input was 0.
REQ-015 out_nar  output  1  input was NaR (1 followed by N-1 zeros).

Function
REQ-016 Transfer occurs on a rising edge with valid && ready on the same port.
REQ-017 Two register stages; an input accepted at edge t is presented at out_valid from edge t+2 when out_ready is held high.
REQ-018 Stage 1 registers sign, the two's-complement magnitude of in_posit (identity when sign=0), the zero flag and the NaR flag.
REQ-019 Stage 2 computes regime run length m and bit r: k = m-1 when r=1, k = -m when r=0; skips the terminating bit; takes the next ES bits as e (zero-padded when truncated); left-aligns the remaining bits below the hidden 1, zero-filled.
REQ-020 Zero or NaR: out_scale=0, out_frac=0, out_sign=in_posit[N-1], and the corresponding flag=1.
REQ-021 A regime run filling all N-1 bits gives |k| = N-2 (maxpos/minpos); no terminating bit is consumed.
REQ-022 Each stage holds when its successor is full and not advancing; in_ready = !s1_full || s2 advancing; s2 advances when !out_valid || out_ready.
REQ-023 Full throughput: one result per cycle while out_ready=1.
REQ-024 Outputs stay stable while out_valid && !out_ready.
REQ-025 No combinational path from in_valid or in_posit to out_*; in_ready depends combinationally on out_ready only.

Reset
REQ-026 While rst_n=0 at a rising edge: both stages are emptied, out_valid=0, all out_* data=0, and any statistics counters=0.
REQ-027 in_ready=0 while rst_n=0; it is 1 on the first cycle after release.
REQ-028 Reset asserted mid-stream discards in-flight words with no output.

Configuration
REQ-029 Macro POSIT_DECODE_STATS_EN defined: adds outputs cnt_zero[15:0] and cnt_nar[15:0], each incremented on an output transfer carrying the corresponding flag, saturating at 16'hFFFF.
REQ-030 Macro undefined: those ports and counters do not exist; all other behaviour is identical.

Structure
REQ-031 Package posit_pkg holds the SW/FW width functions, the NaR and zero constant functions of N, and a result struct typedef {sign, scale, frac, zero, nar}.
REQ-032 Combinational sub-module posit_regime_cnt (leading-run counter: input N-1 bits; outputs m and r) is instantiated in stage 2.

Verification (N=8, ES=0 unless stated)
REQ-033 0x40 with out_ready=1 -> two edges later sign=0, scale=0, frac=6'b100000, zero=0, nar=0.
REQ-034 Stream 0x50, 0xB0, 0x01, 0x7F back-to-back -> (0,0,110000), (1,0,110000), (0,-6,100000), (0,6,100000) on consecutive cycles.
REQ-035 0x00 then 0x80 -> zero=1 then nar=1, scale=0, frac=0; with POSIT_DECODE_STATS_EN defined, cnt_zero=1 and cnt_nar=1.
REQ-036 out_ready=0 for 5 cycles while in_valid=1 -> exactly 2 words accepted, in_ready=0 afterwards, outputs stable; on release, all words are delivered in order with none lost or duplicated.
REQ-037 N=16, ES=1, input 0x5000 -> scale=1, frac=13'h1000; input 0x0001 -> scale=-28.
REQ-038 rst_n=0 for one cycle with 2 words in flight -> out_valid=0 on the next cycle; no stale words appear.

Source files
------------

// File: rtl/posit_decode_pipe_pkg.sv
// -----------------------------------------------------------------------------
// posit_pkg
// Shared definitions for the posit decode pipeline:
//   posit_sw(n, es)  - width of the signed scale field, k*2^es + e
//   posit_fw(n, es)  - width of the fraction field, hidden 1 included
//   posit_nar(n)     - NaR bit pattern (1 followed by n-1 zeros)
//   posit_zero(n)    - zero bit pattern
//   posit_result_t   - decoded result record sized for the widest legal
//                      configuration (N=32, ES=3); narrower decoders use the
//                      low bits of scale (sign-extended) and frac.
// -----------------------------------------------------------------------------
package posit_pkg;

    localparam int SCALE_MAX = 16;
    localparam int FRAC_MAX  = 32;

    function automatic int posit_sw(input int n, input int es);
        return $clog2((n - 2) << es) + 2;
    endfunction

    function automatic int posit_fw(input int n, input int es);
        return n - 2 - es;
    endfunction

    function automatic logic [31:0] posit_nar(input int n);
        return 32'h1 << (n - 1);
    endfunction

    function automatic logic [31:0] posit_zero(input int n);
        return posit_nar(n) & ~posit_nar(n);
    endfunction

    typedef struct packed {
        logic                        sign;
        logic signed [SCALE_MAX-1:0] scale;
        logic [FRAC_MAX-1:0]         frac;
        logic                        zero;
        logic                        nar;
    } posit_result_t;

endpackage

// File: rtl/posit_decode_pipe_if.sv
// -----------------------------------------------------------------------------
// posit_decode_pipe_if
// Valid/ready bundle for the posit decoder: an input posit stream and a
// decoded result stream.
//   master : drives in_valid, in_posit, out_ready; observes the rest
//   slave  : the decoder; drives in_ready and all out_* signals
// -----------------------------------------------------------------------------
interface posit_decode_pipe_if
    import posit_pkg::*;
#(
    parameter int N  = 8,
    parameter int ES = 0
) ();

    localparam int SW = posit_sw(N, ES);
    localparam int FW = posit_fw(N, ES);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_posit;
    logic          out_valid;
    logic          out_ready;
    logic          out_sign;
    logic [SW-1:0] out_scale;
    logic [FW-1:0] out_frac;
    logic          out_zero;
    logic          out_nar;

    modport master (
        output in_valid, in_posit, out_ready,
        input  in_ready, out_valid, out_sign, out_scale, out_frac, out_zero, out_nar
    );

    modport slave (
        input  in_valid, in_posit, out_ready,
        output in_ready, out_valid, out_sign, out_scale, out_frac, out_zero, out_nar
    );

endinterface

// File: rtl/posit_decode_pipe_regime_cnt.sv
// -----------------------------------------------------------------------------
// posit_regime_cnt
// Combinational leading-run counter for the posit regime field.
//   bits : W-bit field, MSB first (posit magnitude without its sign bit)
//   r    : value of the leading bit
//   m    : number of consecutive leading bits equal to r (1..W)
// -----------------------------------------------------------------------------
module posit_regime_cnt #(
    parameter  int W  = 7,
    localparam int MW = $clog2(W + 1)
) (
    input  logic [W-1:0]  bits,
    output logic [MW-1:0] m,
    output logic          r
);

    logic run;

    // NOTE: every variable written here gets a value before any branch so no
    // path leaves it unassigned, which is what keeps this block latch-free.
    always_comb begin
        r   = bits[W-1];
        m   = '0;
        run = 1'b1;
        for (int i = W - 1; i >= 0; i--) begin
            if (run && (bits[i] == r)) begin
                m = m + MW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/posit_decode_pipe.sv
// -----------------------------------------------------------------------------
// posit_decode_pipe
// Two-stage pipelined posit<N,ES> decoder with valid/ready flow control.
//   clk, rst_n : rising-edge clock, synchronous active-low reset
//   bus        : posit_decode_pipe_if.slave
//                  in_valid/in_ready/in_posit   - posit input stream
//                  out_valid/out_ready          - result handshake
//                  out_sign, out_scale (signed k*2^ES+e), out_frac (1.f,
//                  hidden 1 at MSB), out_zero, out_nar
//   cnt_zero, cnt_nar : saturating counts of delivered zero / NaR results,
//                  present only when POSIT_DECODE_STATS_EN is defined
// Stage 1 registers sign, two's-complement magnitude and special-value flags;
// stage 2 splits the magnitude into regime, exponent and fraction.
// -----------------------------------------------------------------------------
module posit_decode_pipe
    import posit_pkg::*;
#(
    parameter int N  = 8,
    parameter int ES = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    posit_decode_pipe_if.slave  bus
`ifdef POSIT_DECODE_STATS_EN
    ,
    output logic [15:0]         cnt_zero,
    output logic [15:0]         cnt_nar
`endif
);

    localparam int SW = posit_sw(N, ES);
    localparam int FW = posit_fw(N, ES);
    localparam int MW = $clog2(N);

    localparam logic [N-1:0] NAR_WORD  = N'(posit_nar(N));
    localparam logic [N-1:0] ZERO_WORD = N'(posit_zero(N));

    // ---------------- flow control ----------------
    logic s1_full, s2_full;
    logic s2_adv, accept;

    assign s2_adv       = !s2_full || bus.out_ready;
    assign bus.in_ready = rst_n && (!s1_full || s2_adv);
    assign accept       = bus.in_valid && bus.in_ready;

    // ---------------- stage 1 ----------------
    logic         s1_sign;
    logic [N-2:0] s1_body;
    logic         s1_zero;
    logic         s1_nar;

    // NOTE: the data registers are cleared on reset as well as the valid
    // flags, because the outputs must read as zero while the pipe is empty
    // after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_full <= 1'b0;
            s1_sign <= 1'b0;
            s1_body <= '0;
            s1_zero <= 1'b0;
            s1_nar  <= 1'b0;
        end else begin
            if (accept) begin
                s1_full <= 1'b1;
            end else if (s2_adv) begin
                s1_full <= 1'b0;
            end
            if (accept) begin
                s1_sign <= bus.in_posit[N-1];
                // Low N-1 bits of the negated word equal the negated low bits.
                s1_body <= bus.in_posit[N-1] ? -bus.in_posit[N-2:0] : bus.in_posit[N-2:0];
                s1_zero <= (bus.in_posit == ZERO_WORD);
                s1_nar  <= (bus.in_posit == NAR_WORD);
            end
        end
    end

    // ---------------- stage 2 decode ----------------
    logic [MW-1:0] run_len;
    logic          run_bit;

    posit_regime_cnt #(.W(N - 1)) u_regime (
        .bits (s1_body),
        .m    (run_len),
        .r    (run_bit)
    );

    // Bits after the regime and its terminator. The run is at least one bit,
    // so the top two body bits never reach the exponent/fraction; shifting the
    // low N-3 bits by (m-1) aligns the first field bit at the MSB. A run that
    // fills the body shifts everything out, so no terminator is consumed.
    logic [N-4:0]  tail;
    int            k_i;
    int            e_i;
    logic [SW-1:0] scale_c;
    logic [FW-1:0] frac_c;

    // NOTE: blocking assignments in combinational logic so each statement sees
    // the value computed just above it; registers use non-blocking only.
    always_comb begin
        tail = s1_body[N-4:0] << (int'(run_len) - 1);
        k_i  = run_bit ? int'(run_len) - 1 : -int'(run_len);
        e_i  = 0;
        for (int i = 0; i < ES; i++) begin
            e_i = (e_i << 1) | int'(tail[N-4-i]);
        end
        scale_c        = SW'(k_i * (2 ** ES) + e_i);
        frac_c         = '0;
        frac_c[FW-1]   = 1'b1;
        for (int i = 0; i < FW - 1; i++) begin
            frac_c[FW-2-i] = tail[N-4-ES-i];
        end
        if (s1_zero || s1_nar) begin
            scale_c = '0;
            frac_c  = '0;
        end
    end

    // ---------------- stage 2 registers ----------------
    logic          s2_sign;
    logic [SW-1:0] s2_scale;
    logic [FW-1:0] s2_frac;
    logic          s2_zero;
    logic          s2_nar;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_full  <= 1'b0;
            s2_sign  <= 1'b0;
            s2_scale <= '0;
            s2_frac  <= '0;
            s2_zero  <= 1'b0;
            s2_nar   <= 1'b0;
        end else if (s2_adv) begin
            s2_full <= s1_full;
            if (s1_full) begin
                s2_sign  <= s1_sign;
                s2_scale <= scale_c;
                s2_frac  <= frac_c;
                s2_zero  <= s1_zero;
                s2_nar   <= s1_nar;
            end
        end
    end

    assign bus.out_valid = s2_full;
    assign bus.out_sign  = s2_sign;
    assign bus.out_scale = s2_scale;
    assign bus.out_frac  = s2_frac;
    assign bus.out_zero  = s2_zero;
    assign bus.out_nar   = s2_nar;

`ifdef POSIT_DECODE_STATS_EN
    // ---------------- statistics ----------------
    logic out_xfer;
    assign out_xfer = s2_full && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_zero <= '0;
            cnt_nar  <= '0;
        end else if (out_xfer) begin
            if (s2_zero && (cnt_zero != 16'hFFFF)) begin
                cnt_zero <= cnt_zero + 16'd1;
            end
            if (s2_nar && (cnt_nar != 16'hFFFF)) begin
                cnt_nar <= cnt_nar + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_posit_decode_pipe.sv
// -----------------------------------------------------------------------------
// tb_posit_decode_pipe
// Self-checking bench: a posit<8,0> and a posit<16,1> decoder driven in
// lockstep. Expected results come from hand-computed tables or from an
// independent bit-walking decoder, queued on input acceptance and compared
// when each result is delivered.
// -----------------------------------------------------------------------------
module tb_posit_decode_pipe;
    import posit_pkg::*;

    logic clk;
    logic rst_n;

    posit_decode_pipe_if #(.N(8),  .ES(0)) b8 ();
    posit_decode_pipe_if #(.N(16), .ES(1)) b16 ();

`ifdef POSIT_DECODE_STATS_EN
    logic [15:0] cz8, cn8, cz16, cn16;
`endif

    posit_decode_pipe #(.N(8), .ES(0)) u8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8)
`ifdef POSIT_DECODE_STATS_EN
        ,
        .cnt_zero (cz8),
        .cnt_nar  (cn8)
`endif
    );

    posit_decode_pipe #(.N(16), .ES(1)) u16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b16)
`ifdef POSIT_DECODE_STATS_EN
        ,
        .cnt_zero (cz16),
        .cnt_nar  (cn16)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    posit_result_t q8[$];
    posit_result_t q16[$];

    logic          acc8, fire8, inrdy8, oval8;
    logic          acc16, fire16;
    posit_result_t act8, act16;

    task automatic check(input string name, input logic ok, input string detail);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic string fmt(input posit_result_t r);
        return $sformatf("s=%0d sc=%0d f=%h z=%0d n=%0d",
                         r.sign, $signed(r.scale), r.frac, r.zero, r.nar);
    endfunction

    function automatic posit_result_t mk(input logic sg, input int sc, input logic [31:0] fr,
                                         input logic z, input logic n);
        posit_result_t r;
        r       = '0;
        r.sign  = sg;
        r.scale = 16'(sc);
        r.frac  = fr;
        r.zero  = z;
        r.nar   = n;
        return r;
    endfunction

    // Independent reference: walk the magnitude bit by bit.
    function automatic posit_result_t ref_decode(input int n, input int es, input logic [31:0] p_in);
        posit_result_t res;
        logic [31:0]   mask, p, mag;
        logic          r;
        int            i, cnt, k, e, f;
        mask     = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
        p        = p_in & mask;
        res      = '0;
        res.sign = p[n-1];
        if (p == 32'h0) begin
            res.zero = 1'b1;
            return res;
        end
        if (p == (32'h1 << (n - 1))) begin
            res.nar = 1'b1;
            return res;
        end
        mag = res.sign ? ((~p + 32'h1) & mask) : p;
        i   = n - 2;
        r   = mag[i];
        cnt = 0;
        while (i >= 0 && mag[i] == r) begin
            cnt++;
            i--;
        end
        k = r ? cnt - 1 : -cnt;
        i--;
        e = 0;
        for (int j = 0; j < es; j++) begin
            e = e * 2 + ((i >= 0) ? int'(mag[i]) : 0);
            i--;
        end
        f = 1;
        for (int j = 0; j < n - 3 - es; j++) begin
            f = f * 2 + ((i >= 0) ? int'(mag[i]) : 0);
            i--;
        end
        res.scale = 16'(k * (1 << es) + e);
        res.frac  = 32'(f);
        return res;
    endfunction

    function automatic posit_result_t grab8();
        posit_result_t r;
        int            s;
        s       = $signed(b8.out_scale);
        r       = '0;
        r.sign  = b8.out_sign;
        r.scale = 16'(s);
        r.frac  = 32'(b8.out_frac);
        r.zero  = b8.out_zero;
        r.nar   = b8.out_nar;
        return r;
    endfunction

    function automatic posit_result_t grab16();
        posit_result_t r;
        int            s;
        s       = $signed(b16.out_scale);
        r       = '0;
        r.sign  = b16.out_sign;
        r.scale = 16'(s);
        r.frac  = 32'(b16.out_frac);
        r.zero  = b16.out_zero;
        r.nar   = b16.out_nar;
        return r;
    endfunction

    // One clock cycle on both decoders: drive at the falling edge, sample 1ns
    // later, score deliveries, then record acceptances after the rising edge.
    task automatic cycle(input logic v8, input logic [7:0] p8, input logic r8, input posit_result_t e8,
                         input logic v16, input logic [15:0] p16, input logic r16,
                         input posit_result_t e16);
        posit_result_t exp_r;
        @(negedge clk);
        b8.in_valid   = v8;
        b8.in_posit   = p8;
        b8.out_ready  = r8;
        b16.in_valid  = v16;
        b16.in_posit  = p16;
        b16.out_ready = r16;
        #1;
        inrdy8 = b8.in_ready;
        oval8  = b8.out_valid;
        acc8   = v8 && b8.in_ready;
        fire8  = b8.out_valid && r8;
        act8   = grab8();
        acc16  = v16 && b16.in_ready;
        fire16 = b16.out_valid && r16;
        act16  = grab16();
        if (fire8) begin
            if (q8.size() == 0) begin
                check("unexpected_out8", 1'b0, $sformatf("got %s with nothing pending", fmt(act8)));
            end else begin
                exp_r = q8.pop_front();
                check("out8", act8 == exp_r, $sformatf("got %s want %s", fmt(act8), fmt(exp_r)));
            end
        end
        if (fire16) begin
            if (q16.size() == 0) begin
                check("unexpected_out16", 1'b0, $sformatf("got %s with nothing pending", fmt(act16)));
            end else begin
                exp_r = q16.pop_front();
                check("out16", act16 == exp_r, $sformatf("got %s want %s", fmt(act16), fmt(exp_r)));
            end
        end
        @(posedge clk);
        if (acc8)  q8.push_back(e8);
        if (acc16) q16.push_back(e16);
    endtask

    task automatic drive8(input logic v, input logic [7:0] p, input logic r, input posit_result_t e);
        cycle(v, p, r, e, 1'b0, 16'h0, 1'b1, '0);
    endtask

    task automatic drive16(input logic [15:0] p, input posit_result_t e);
        cycle(1'b0, 8'h0, 1'b1, '0, 1'b1, p, 1'b1, e);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 8'h0, 1'b1, '0, 1'b0, 16'h0, 1'b1, '0);
    endtask

    typedef struct {
        logic [7:0] p;
        logic       sg;
        int         sc;
        logic [5:0] fr;
        logic       z;
        logic       n;
    } vec8_t;

    vec8_t         tbl[14];
    posit_result_t sw_exp[5];
    logic [7:0]    sw_word[5];
    posit_result_t snap;
    logic [5:0]    fires;
    logic [7:0]    rp8;
    logic [15:0]   rp16;
    int            idx;
    int            guard;
    logic          have_snap;

    initial begin
        tbl[0]  = '{8'h40, 1'b0,  0, 6'b100000, 1'b0, 1'b0};
        tbl[1]  = '{8'h50, 1'b0,  0, 6'b110000, 1'b0, 1'b0};
        tbl[2]  = '{8'hB0, 1'b1,  0, 6'b110000, 1'b0, 1'b0};
        tbl[3]  = '{8'h01, 1'b0, -6, 6'b100000, 1'b0, 1'b0};
        tbl[4]  = '{8'h7F, 1'b0,  6, 6'b100000, 1'b0, 1'b0};
        tbl[5]  = '{8'h00, 1'b0,  0, 6'b000000, 1'b1, 1'b0};
        tbl[6]  = '{8'h80, 1'b1,  0, 6'b000000, 1'b0, 1'b1};
        tbl[7]  = '{8'h60, 1'b0,  1, 6'b100000, 1'b0, 1'b0};
        tbl[8]  = '{8'h20, 1'b0, -1, 6'b100000, 1'b0, 1'b0};
        tbl[9]  = '{8'h48, 1'b0,  0, 6'b101000, 1'b0, 1'b0};
        tbl[10] = '{8'hC0, 1'b1,  0, 6'b100000, 1'b0, 1'b0};
        tbl[11] = '{8'hFF, 1'b1, -6, 6'b100000, 1'b0, 1'b0};
        tbl[12] = '{8'h81, 1'b1,  6, 6'b100000, 1'b0, 1'b0};
        tbl[13] = '{8'h03, 1'b0, -5, 6'b110000, 1'b0, 1'b0};

        rst_n         = 1'b0;
        b8.in_valid   = 1'b0;
        b8.in_posit   = 8'h0;
        b8.out_ready  = 1'b1;
        b16.in_valid  = 1'b0;
        b16.in_posit  = 16'h0;
        b16.out_ready = 1'b1;

        // ---- reset ----
        repeat (2) @(negedge clk);
        check("in_ready_in_reset", !b8.in_ready && !b16.in_ready,
              $sformatf("got %0d/%0d want 0/0", b8.in_ready, b16.in_ready));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_reset", b8.in_ready && b16.in_ready,
              $sformatf("got %0d/%0d want 1/1", b8.in_ready, b16.in_ready));
        check("out_after_reset",
              !b8.out_valid && !b16.out_valid && grab8() == '0 && grab16() == '0,
              $sformatf("got v=%0d %s want v=0 all zero", b8.out_valid, fmt(grab8())));

        // ---- single word latency: accepted at edge t, delivered at edge t+2 ----
        drive8(1'b1, 8'h40, 1'b1, mk(1'b0, 0, 32'h20, 1'b0, 1'b0));
        drive8(1'b0, 8'h00, 1'b1, '0);
        check("latency_edge1", !fire8, $sformatf("got out_valid=%0d want 0", oval8));
        drive8(1'b0, 8'h00, 1'b1, '0);
        check("latency_edge2", fire8, $sformatf("got out_valid=%0d want 1", oval8));

        // ---- zero and NaR ----
        drive8(1'b1, 8'h00, 1'b1, mk(1'b0, 0, 32'h0, 1'b1, 1'b0));
        drive8(1'b1, 8'h80, 1'b1, mk(1'b1, 0, 32'h0, 1'b0, 1'b1));
        idle(3);
`ifdef POSIT_DECODE_STATS_EN
        check("stats_counts", cz8 == 16'd1 && cn8 == 16'd1,
              $sformatf("got zero=%0d nar=%0d want 1/1", cz8, cn8));
`endif

        // ---- vector table, back to back ----
        for (int i = 0; i < 14; i++) begin
            drive8(1'b1, tbl[i].p, 1'b1, mk(tbl[i].sg, tbl[i].sc, 32'(tbl[i].fr), tbl[i].z, tbl[i].n));
        end
        idle(3);

        // ---- full throughput: four words, four consecutive results ----
        fires = '0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                drive8(1'b1, tbl[i + 1].p, 1'b1,
                       mk(tbl[i + 1].sg, tbl[i + 1].sc, 32'(tbl[i + 1].fr), 1'b0, 1'b0));
            end else begin
                drive8(1'b0, 8'h00, 1'b1, '0);
            end
            fires[5 - i] = fire8;
        end
        check("throughput", fires == 6'b001111, $sformatf("got %b want 001111", fires));

        // ---- back-pressure: out_ready low for 5 cycles ----
        sw_word[0] = 8'h48; sw_exp[0] = mk(1'b0,  0, 32'h28, 1'b0, 1'b0);
        sw_word[1] = 8'h30; sw_exp[1] = mk(1'b0, -1, 32'h30, 1'b0, 1'b0);
        sw_word[2] = 8'h03; sw_exp[2] = mk(1'b0, -5, 32'h30, 1'b0, 1'b0);
        sw_word[3] = 8'hC0; sw_exp[3] = mk(1'b1,  0, 32'h20, 1'b0, 1'b0);
        sw_word[4] = 8'h20; sw_exp[4] = mk(1'b0, -1, 32'h20, 1'b0, 1'b0);
        idx       = 0;
        have_snap = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive8(1'b1, sw_word[idx], 1'b0, sw_exp[idx]);
            if (acc8) idx++;
            if (oval8) begin
                if (have_snap) begin
                    check("stall_stable", act8 == snap,
                          $sformatf("got %s want %s", fmt(act8), fmt(snap)));
                end
                snap      = act8;
                have_snap = 1'b1;
            end
        end
        check("stall_accepted", idx == 2, $sformatf("got %0d want 2", idx));
        check("stall_in_ready", !inrdy8, $sformatf("got %0d want 0", inrdy8));
        guard = 0;
        while (idx < 5 && guard < 20) begin
            drive8(1'b1, sw_word[idx], 1'b1, sw_exp[idx]);
            if (acc8) idx++;
            guard++;
        end
        check("stall_release", idx == 5, $sformatf("got %0d accepted want 5", idx));
        idle(4);
        check("stall_drained", q8.size() == 0, $sformatf("got %0d pending want 0", q8.size()));

        // ---- 16-bit, ES=1 ----
        drive16(16'h5000, mk(1'b0,   1, 32'h1000, 1'b0, 1'b0));
        drive16(16'h0001, mk(1'b0, -28, 32'h1000, 1'b0, 1'b0));
        drive16(16'h4800, mk(1'b0,   0, 32'h1800, 1'b0, 1'b0));
        drive16(16'h7FFF, mk(1'b0,  28, 32'h1000, 1'b0, 1'b0));
        drive16(16'hC000, mk(1'b1,   0, 32'h1000, 1'b0, 1'b0));
        drive16(16'h8000, mk(1'b1,   0, 32'h0,    1'b0, 1'b1));
        idle(3);

        // ---- random traffic with random back-pressure on both decoders ----
        for (int i = 0; i < 200; i++) begin
            rp8  = 8'($urandom);
            rp16 = 16'($urandom);
            cycle(1'($urandom_range(0, 1)), rp8, 1'($urandom_range(0, 3) != 0),
                  ref_decode(8, 0, 32'(rp8)),
                  1'($urandom_range(0, 1)), rp16, 1'($urandom_range(0, 3) != 0),
                  ref_decode(16, 1, 32'(rp16)));
        end
        idle(4);

        // ---- reset with two words in flight ----
        drive8(1'b1, 8'h50, 1'b0, mk(1'b0, 0, 32'h30, 1'b0, 1'b0));
        drive8(1'b1, 8'hB0, 1'b0, mk(1'b1, 0, 32'h30, 1'b0, 1'b0));
        check("inflight_count", q8.size() == 2, $sformatf("got %0d want 2", q8.size()));
        @(negedge clk);
        rst_n        = 1'b0;
        b8.in_valid  = 1'b0;
        b16.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q8.delete();
        q16.delete();
        #1;
        check("reset_midstream_valid", !b8.out_valid, $sformatf("got %0d want 0", b8.out_valid));
        idle(3);
        drive8(1'b1, 8'h7F, 1'b1, mk(1'b0, 6, 32'h20, 1'b0, 1'b0));
        idle(3);

        check("end_queue8", q8.size() == 0, $sformatf("got %0d pending want 0", q8.size()));
        check("end_queue16", q16.size() == 0, $sformatf("got %0d pending want 0", q16.size()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
